// File: rtl/reboot_pkg.sv
// Shared definitions for the reboot request controller.
// Contents: register address map, unlock key values, command codes,
// the controller state enum and the highest legal core id.
package reboot_pkg;

    // Register select values on wr_addr (3 is reserved; writes to it are ignored)
    localparam logic [1:0] AddrKey    = 2'd0;
    localparam logic [1:0] AddrCoreId = 2'd1;
    localparam logic [1:0] AddrCmd    = 2'd2;

    // Two-step unlock sequence written to the KEY register
    localparam logic [7:0] KeyFirst  = 8'h55;
    localparam logic [7:0] KeySecond = 8'hAA;

    // CMD register codes
    localparam logic [7:0] CmdCore    = 8'h01;
    localparam logic [7:0] CmdDefault = 8'h02;

    // Ids 1..20 map to flash pages 0x0B0..0xF3C; id 0 wraps the address math
    localparam int unsigned MaxCoreId = 20;

    typedef enum logic [2:0] {
        StLocked,
        StKey1,
        StArmed,
        StDelay,
        StFire,
        StHalt
    } state_e;

endpackage

// File: rtl/reboot_request_ctrl_if.sv
// CPU-side register write bus of the reboot request controller.
//   wr_stb  : one-cycle write strobe
//   wr_addr : register select (0=KEY, 1=CORE_ID, 2=CMD, 3=reserved)
//   wr_data : write data
// master drives the bus (CPU / testbench), slave samples it (controller).
interface reboot_request_ctrl_if;

    logic       wr_stb;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        output wr_stb,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input wr_stb,
        input wr_addr,
        input wr_data
    );

endinterface

// File: rtl/reboot_down_counter.sv
// Loadable down counter with a zero flag; saturates at zero.
//   clk      : clock
//   reset_n  : synchronous active-low reset (count -> 0)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one when nonzero
//   zero     : high while the count is 0
module reboot_down_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/reboot_request_ctrl.sv
// Reboot request controller: turns CPU register writes into a key-protected,
// range-checked reboot request for the multiboot ICAP block. A quiesce
// warning is raised for DELAY_CYCLES before the selected reboot line is held
// for HOLD_CYCLES; the block then halts until reset.
//   clk_icap         : system clock (shared with multiboot)
//   reset_n_i        : synchronous active-low reset
//   wr               : register write bus (slave side)
//   reboot_o         : default-core reboot line
//   reboot_core_x_o  : core reboot line
//   reboot_core_id_o : latched 5-bit core id
//   quiesce_o        : high during DELAY and FIRE
//   busy_o           : high in any state other than LOCKED
//   err_o            : sticky error, cleared by a successful unlock
module reboot_request_ctrl
    import reboot_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES  = 16,
    parameter int unsigned KEY_TIMEOUT  = 65535,
    parameter int unsigned MAX_CORE_ID  = MaxCoreId
) (
    input  logic                  clk_icap,
    input  logic                  reset_n_i,
    reboot_request_ctrl_if.slave  wr,
    output logic                  reboot_o,
    output logic                  reboot_core_x_o,
    output logic [4:0]            reboot_core_id_o,
    output logic                  quiesce_o,
    output logic                  busy_o,
    output logic                  err_o
);

    state_e     state_q;
    logic [4:0] id_q;
    logic       core_req_q;
    logic       reboot_q, core_x_q, quiesce_q, busy_q, err_q;

    logic        any_wr, key_wr, id_wr, cmd_wr;
    logic        id_ok, cmd_core, cmd_ok;
    logic        tmo_load, tmo_zero;
    logic        start, dh_load, dh_dec, dh_zero;
    logic [15:0] dh_val;

    always_comb begin
        any_wr   = wr.wr_stb && (wr.wr_addr != 2'd3);
        key_wr   = wr.wr_stb && (wr.wr_addr == AddrKey);
        id_wr    = wr.wr_stb && (wr.wr_addr == AddrCoreId);
        cmd_wr   = wr.wr_stb && (wr.wr_addr == AddrCmd);
        id_ok    = (wr.wr_data[7:5] == 3'd0) && (wr.wr_data[4:0] != 5'd0) &&
                   (wr.wr_data[4:0] <= 5'(MAX_CORE_ID));
        cmd_core = (wr.wr_data == CmdCore) && (id_q != 5'd0);
        cmd_ok   = cmd_core || (wr.wr_data == CmdDefault);
        tmo_load = (state_q == StKey1) && key_wr && (wr.wr_data == KeySecond);
        // Timeout expiry wins over a write on the same edge
        start    = (state_q == StArmed) && !tmo_zero && cmd_wr && cmd_ok;
        // Counter reloads: D-1 on accept so FIRE starts D edges later, H-1 on FIRE entry
        dh_load  = start || ((state_q == StDelay) && dh_zero);
        dh_val   = start ? 16'(DELAY_CYCLES - 1) : 16'(HOLD_CYCLES - 1);
        dh_dec   = (state_q == StDelay) || (state_q == StFire);
    end

    reboot_down_counter #(.Width(16)) u_timeout (
        .clk      (clk_icap),
        .reset_n  (reset_n_i),
        .load     (tmo_load),
        .load_val (16'(KEY_TIMEOUT)),
        .dec      (state_q == StArmed),
        .zero     (tmo_zero)
    );

    reboot_down_counter #(.Width(16)) u_delay_hold (
        .clk      (clk_icap),
        .reset_n  (reset_n_i),
        .load     (dh_load),
        .load_val (dh_val),
        .dec      (dh_dec),
        .zero     (dh_zero)
    );

    always_ff @(posedge clk_icap) begin
        if (!reset_n_i) begin
            state_q    <= StLocked;
            id_q       <= 5'd0;
            core_req_q <= 1'b0;
            reboot_q   <= 1'b0;
            core_x_q   <= 1'b0;
            quiesce_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StLocked: begin
                    if (key_wr && (wr.wr_data == KeyFirst)) begin
                        state_q <= StKey1;
                        busy_q  <= 1'b1;
                    end
                end
                StKey1: begin
                    if (tmo_load) begin
                        state_q <= StArmed;
                        err_q   <= 1'b0;
                    end else if (any_wr) begin
                        state_q <= StLocked;
                        busy_q  <= 1'b0;
                    end
                end
                StArmed: begin
                    if (tmo_zero) begin
                        state_q <= StLocked;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (id_wr) begin
                        if (id_ok) begin
                            id_q <= wr.wr_data[4:0];
                        end else begin
                            state_q <= StLocked;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end else if (cmd_wr) begin
                        if (cmd_ok) begin
                            state_q    <= StDelay;
                            quiesce_q  <= 1'b1;
                            core_req_q <= cmd_core;
                        end else begin
                            state_q <= StLocked;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end else if (key_wr) begin
                        state_q <= StLocked;
                        busy_q  <= 1'b0;
                    end
                end
                StDelay: begin
                    if (dh_zero) begin
                        state_q  <= StFire;
                        core_x_q <= core_req_q;
                        reboot_q <= !core_req_q;
                    end
                end
                StFire: begin
                    if (dh_zero) begin
                        state_q   <= StHalt;
                        core_x_q  <= 1'b0;
                        reboot_q  <= 1'b0;
                        quiesce_q <= 1'b0;
                    end
                end
                StHalt: begin
                    // Parked until reset so a slow reconfiguration never sees a second edge
                    state_q <= StHalt;
                end
                default: begin
                    state_q <= StLocked;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign reboot_o         = reboot_q;
    assign reboot_core_x_o  = core_x_q;
    assign reboot_core_id_o = id_q;
    assign quiesce_o        = quiesce_q;
    assign busy_o           = busy_q;
    assign err_o            = err_q;

endmodule
